// File: rtl/mult_pkg.sv
// Shared constants and capture FSM encoding for the multiplier result path.
package mult_pkg;

  localparam int PROD_W = 64;
  localparam int OUT_W  = 32;

  // Capture handshake states; encoding is fixed so control-side checks can reuse it.
  typedef enum logic {
    S_IDLE = 1'b0,
    S_ACK  = 1'b1
  } cap_state_e;

endpackage

// File: rtl/result_fifo.sv
// Small product FIFO: DEPTH x WIDTH storage with wrapping pointers and an occupancy count.
module result_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 64,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] head_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    count_d = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
  end

  // Pointer and occupancy state; storage contents need no reset.
  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage write; the head is read combinationally so a fresh entry is visible next cycle.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/mult_result_buffer.sv
// Captures finished products with a 4-phase ack, queues them, and streams each as two beats.
module mult_result_buffer
  import mult_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              iDone,
  input  logic [PROD_W-1:0] iProduct,
  output logic              oAck,
  output logic [OUT_W-1:0]  oData,
  output logic              oValid,
  input  logic              iReady,
  output logic              oHalf,
  output logic [CNT_W-1:0]  oCount,
  output logic              oFull
);

  cap_state_e        state_q, state_d;
  logic              half_q,  half_d;
  logic              push, pop, xfer, fifo_empty;
  logic [PROD_W-1:0] head;

  // A capture only starts from idle and only when the FIFO was not full at cycle start.
  assign push = (state_q == S_IDLE) && iDone && !oFull;
  assign xfer = oValid && iReady;
  assign pop  = xfer && half_q;

  result_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (PROD_W)
  ) u_fifo (
    .clk     (Clock),
    .srst    (Reset),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (iProduct),
    .head_o  (head),
    .count_o (oCount),
    .full_o  (oFull),
    .empty_o (fifo_empty)
  );

  // Capture FSM next state: hold ack until the multiplier drops iDone.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (push)   state_d = S_ACK;
      S_ACK:   if (!iDone) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Capture FSM state register; oAck is decoded straight from it.
  always_ff @(posedge Clock) begin
    if (Reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  assign oAck = (state_q == S_ACK);

  // Beat selector toggles on every accepted beat; the high beat retires the head entry.
  always_comb begin
    half_d = half_q;
    if (xfer) half_d = ~half_q;
  end

  // Serializer phase register.
  always_ff @(posedge Clock) begin
    if (Reset) half_q <= 1'b0;
    else       half_q <= half_d;
  end

  assign oValid = !fifo_empty;
  assign oHalf  = half_q;
  assign oData  = !oValid ? '0 :
                  half_q  ? head[PROD_W-1:OUT_W] : head[OUT_W-1:0];

endmodule

// File: doc/mult_result_buffer.md
Name: mult_result_buffer

Overview:
Downstream stage of the shift-add multiplier. It captures each finished 64-bit product, returns the 4-phase acknowledge (`iAck`) to the multiplier control machine, and queues products in a small FIFO. Products leave on a 32-bit valid/ready stream as two beats each, low word first. It replaces the bench's canned ack generator in the integrated design and exerts backpressure on the multiplier when the FIFO is full.

Parameters:
- PROD_W, 64, product width from the datapath
- OUT_W, 32, output beat width; PROD_W must equal 2*OUT_W
- DEPTH, 4, FIFO entries; must be a power of 2 and at least 2

Ports:
- Clock  input  1  system clock; all logic on the rising edge
- Reset  input  1  synchronous, active-high reset
- iDone  input  1  multiplier product valid; level signal, held high until oAck is seen
- iProduct  input  PROD_W  product from the datapath; stable while iDone=1
- oAck  output  1  acknowledge to the control machine (drives its iAck)
- oData  output  OUT_W  current output beat
- oValid  output  1  oData is valid
- iReady  input  1  consumer accepts the beat when oValid=1 and iReady=1
- oHalf  output  1  0 = low word beat, 1 = high word beat
- oCount  output  $clog2(DEPTH)+1  number of FIFO entries occupied
- oFull  output  1  oCount == DEPTH

Behaviour:
Reset (synchronous, active-high), applied at any time:
- Next edge: oAck=0, oValid=0, oData=0, oHalf=0, oCount=0, oFull=0.
- Read and write pointers cleared; capture FSM returns to S_IDLE.
- A handshake in progress is abandoned; the multiplier must be reset together with this block.

Capture FSM, two states:
- S_IDLE: oAck=0.
  - If iDone=1 and oFull=0 at an edge: write iProduct into the FIFO at that edge and move to S_ACK.
  - If iDone=1 and oFull=1: stay in S_IDLE, no write, no ack. This backpressures the multiplier.
- S_ACK: oAck=1 (registered output).
  - Stays in S_ACK while iDone=1. No further writes occur, however long iDone is held.
  - iDone=0 at an edge: go to S_IDLE; oAck=0 from the next cycle.
- Latency: iDone sampled high at edge n → entry written at edge n; oAck=1 and oValid=1 from cycle n+1.
- Earliest second capture: one cycle after iDone has been seen low.

Output serializer:
- oValid = (oCount != 0).
- oData = oHalf ? head[PROD_W-1:OUT_W] : head[OUT_W-1:0] when oValid=1; oData=0 when oValid=0.
- Beat transfer (oValid & iReady) with oHalf=0: oHalf becomes 1.
- Beat transfer with oHalf=1: oHalf becomes 0, the head entry is popped and the read pointer advances with wrap modulo DEPTH.
- iReady=0: oData and oHalf hold; the head entry is never modified.

FIFO rules:
- Write and read pointers wrap modulo DEPTH.
- Push and pop in the same cycle: oCount is unchanged and both pointers advance.
- The full check for a capture uses the oFull value registered at the start of the cycle. A push is refused when full even if a pop happens in that cycle; the capture succeeds on the following edge.
- Overflow and underflow are impossible by construction; assertions in the bench check this.

Arithmetic:
- Products are stored unsigned with no width change.
- oCount is updated as oCount + push − pop.

Decomposition:
- Package mult_pkg holds PROD_W and OUT_W constants, plus the capture FSM state encoding (S_IDLE=1'b0, S_ACK=1'b1) for sharing with control_Machine assertions.
- One natural sub-module: result_fifo (parameterised DEPTH × PROD_W storage, pointers, count, full/empty).
- The capture FSM and serializer stay in the top module.

Test Plan:
1. Reset; iDone=1 with iProduct=64'h0000_0000_0035_5552 (10*349525), iReady=1 → oAck=1 next cycle. oData=32'h0035_5552 with oHalf=0, then 32'h0000_0000 with oHalf=1. oCount ends at 0.
2. iReady=0; four products 1,2,3,4 captured → oFull=1, oCount=4. A fifth iDone gets no oAck. Raise iReady for two beats → entry 1 popped, fifth product captured and acked within 2 cycles after the pop.
3. Product 64'hDEAD_BEEF_CAFE_F00D with iReady toggling 1,0,0,1 → beats 32'hCAFE_F00D then 32'hDEAD_BEEF. oData is stable while iReady=0.
4. iDone held high 5 cycles → exactly one FIFO write (oCount=1); oAck high until the cycle after iDone falls.
5. Reset asserted while in S_ACK with oCount=2 → next edge oAck=0, oCount=0, oValid=0, oHalf=0.
6. oCount=2, final (high) beat accepted on the same edge as an iDone capture → oCount stays 2. Pointers wrap correctly after 9 total products, checked against a scoreboard.
